// File: rtl/rename_pkg.sv
// Shared widths and bundle types for the two-wide rename stage and its map tables.
package rename_pkg;

    localparam int ARCH_REGS  = 32;
    localparam int PHY_REGS   = 64;
    localparam int ARCH_WIDTH = 5;
    localparam int PHY_WIDTH  = 6;
    localparam int FREE_REG   = 32;
    localparam int FREE_CNT_W = $clog2(FREE_REG) + 1;

    localparam logic [PHY_WIDTH-1:0] PHY_ZERO = '0;

    typedef struct packed {
        logic [PHY_WIDTH-1:0] rs1;
        logic [PHY_WIDTH-1:0] rs2;
        logic [PHY_WIDTH-1:0] rd;
        logic [PHY_WIDTH-1:0] rd_old;
    } rename_slot_t;

endpackage

// File: rtl/rename_map_table.sv
// Architectural-to-physical map: 4 async read ports, 2 ordered write ports
// (port 1 wins on a shared address) and a whole-table bulk load.
module rename_map_table
    import rename_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [3:0][ARCH_WIDTH-1:0]           rd_addr_i,
    output logic [3:0][PHY_WIDTH-1:0]            rd_data_o,
    input  logic [1:0]                           we_i,
    input  logic [1:0][ARCH_WIDTH-1:0]           wr_addr_i,
    input  logic [1:0][PHY_WIDTH-1:0]            wr_data_i,
    input  logic                                 load_i,
    input  logic [ARCH_REGS-1:0][PHY_WIDTH-1:0]  load_data_i,
    output logic [ARCH_REGS-1:0][PHY_WIDTH-1:0]  table_o
);

    logic [ARCH_REGS-1:0][PHY_WIDTH-1:0] map_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= PHY_WIDTH'(i);
            end
        end else if (load_i) begin
            map_q <= load_data_i;
        end else begin
            // Arch 0 is hardwired to phys 0 and never rewritten.
            for (int w = 0; w < 2; w++) begin
                if (we_i[w] && wr_addr_i[w] != '0) begin
                    map_q[wr_addr_i[w]] <= wr_data_i[w];
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            rd_data_o[r] = map_q[rd_addr_i[r]];
        end
    end

    assign table_o = map_q;

endmodule

// File: rtl/rename_stage.sv
// Two-wide rename stage: freelist consumer, speculative front RAT, committed RAT,
// registered output bundle. Define RENAME_PERF_EN to add stall counters.
module rename_stage
    import rename_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [1:0]            in_valid,
    output logic                  in_ready,
    input  logic [ARCH_WIDTH-1:0] rs1_arch_0,
    input  logic [ARCH_WIDTH-1:0] rs2_arch_0,
    input  logic [ARCH_WIDTH-1:0] rd_arch_0,
    input  logic                  rd_we_0,
    input  logic [ARCH_WIDTH-1:0] rs1_arch_1,
    input  logic [ARCH_WIDTH-1:0] rs2_arch_1,
    input  logic [ARCH_WIDTH-1:0] rd_arch_1,
    input  logic                  rd_we_1,
    output logic [1:0]            alloc_req,
    input  logic [PHY_WIDTH-1:0]  alloc_phy_0,
    input  logic [PHY_WIDTH-1:0]  alloc_phy_1,
    input  logic [FREE_CNT_W-1:0] num_free,
    input  logic                  retire_valid,
    input  logic [ARCH_WIDTH-1:0] retire_rd_arch,
    input  logic [PHY_WIDTH-1:0]  retire_rd_phy_new,
    output logic [1:0]            out_valid,
    input  logic                  out_ready,
    output logic [PHY_WIDTH-1:0]  rs1_phy_0,
    output logic [PHY_WIDTH-1:0]  rs2_phy_0,
    output logic [PHY_WIDTH-1:0]  rd_phy_0,
    output logic [PHY_WIDTH-1:0]  rd_phy_old_0,
    output logic [PHY_WIDTH-1:0]  rs1_phy_1,
    output logic [PHY_WIDTH-1:0]  rs2_phy_1,
    output logic [PHY_WIDTH-1:0]  rd_phy_1,
    output logic [PHY_WIDTH-1:0]  rd_phy_old_1
`ifdef RENAME_PERF_EN
    ,
    output logic [31:0]           stall_free_cnt,
    output logic [31:0]           stall_out_cnt
`endif
);

    // Handshake: a group transfers when in_valid != 0 && in_ready; the bundle
    // transfers when out_valid != 0 && out_ready, and holds stable otherwise.
    logic                  need_0, need_1;
    logic [FREE_CNT_W-1:0] need_cnt;
    logic                  out_busy, free_ok, fire;
    logic [PHY_WIDTH-1:0]  new_0, new_1;

    logic [3:0][ARCH_WIDTH-1:0]          frat_raddr;
    logic [3:0][PHY_WIDTH-1:0]           frat_rdata;
    logic [ARCH_REGS-1:0][PHY_WIDTH-1:0] frat_tbl, crat_tbl, crat_merged;
    logic [3:0][PHY_WIDTH-1:0]           unused_crat_rd;

    rename_slot_t slot_0, slot_1;
    rename_slot_t slot0_q, slot0_d, slot1_q, slot1_d;
    logic [1:0]   out_valid_q, out_valid_d;

    assign need_0   = in_valid[0] && rd_we_0 && rd_arch_0 != '0;
    assign need_1   = in_valid[1] && rd_we_1 && rd_arch_1 != '0;
    assign need_cnt = FREE_CNT_W'(need_0) + FREE_CNT_W'(need_1);
    assign out_busy = out_valid_q != 2'b00 && !out_ready;
    assign free_ok  = num_free >= need_cnt;
    assign in_ready = !rst && !flush && !out_busy && free_ok;
    assign fire     = in_ready && in_valid != 2'b00;

    assign alloc_req = {fire && need_1, fire && need_0};
    assign new_0     = alloc_phy_0;
    assign new_1     = need_0 ? alloc_phy_1 : alloc_phy_0;

    assign frat_raddr = {rs2_arch_1, rs1_arch_1, rs2_arch_0, rs1_arch_0};

    // Flush restores from the committed map including this cycle's retirement.
    always_comb begin
        crat_merged = crat_tbl;
        if (retire_valid && retire_rd_arch != '0) begin
            crat_merged[retire_rd_arch] = retire_rd_phy_new;
        end
    end

    rename_map_table u_front_rat (
        .clk         (clk),
        .rst         (rst),
        .rd_addr_i   (frat_raddr),
        .rd_data_o   (frat_rdata),
        .we_i        ({fire && need_1, fire && need_0}),
        .wr_addr_i   ({rd_arch_1, rd_arch_0}),
        .wr_data_i   ({new_1, new_0}),
        .load_i      (flush),
        .load_data_i (crat_merged),
        .table_o     (frat_tbl)
    );

    rename_map_table u_commit_rat (
        .clk         (clk),
        .rst         (rst),
        .rd_addr_i   ('0),
        .rd_data_o   (unused_crat_rd),
        .we_i        ({1'b0, retire_valid}),
        .wr_addr_i   ({{ARCH_WIDTH{1'b0}}, retire_rd_arch}),
        .wr_data_i   ({PHY_ZERO, retire_rd_phy_new}),
        .load_i      (1'b0),
        .load_data_i ('0),
        .table_o     (crat_tbl)
    );

    // Slot 1 sees slot 0's new mapping when it touches slot 0's destination.
    always_comb begin
        slot_0 = '0;
        slot_1 = '0;
        if (in_valid[0]) begin
            slot_0.rs1 = frat_rdata[0];
            slot_0.rs2 = frat_rdata[1];
            if (need_0) begin
                slot_0.rd     = new_0;
                slot_0.rd_old = frat_tbl[rd_arch_0];
            end
        end
        if (in_valid[1]) begin
            slot_1.rs1 = (need_0 && rs1_arch_1 == rd_arch_0) ? new_0 : frat_rdata[2];
            slot_1.rs2 = (need_0 && rs2_arch_1 == rd_arch_0) ? new_0 : frat_rdata[3];
            if (need_1) begin
                slot_1.rd     = new_1;
                slot_1.rd_old = (need_0 && rd_arch_1 == rd_arch_0) ? new_0
                                                                   : frat_tbl[rd_arch_1];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        slot0_d     = slot0_q;
        slot1_d     = slot1_q;
        if (flush) begin
            out_valid_d = 2'b00;
            slot0_d     = '0;
            slot1_d     = '0;
        end else if (fire) begin
            out_valid_d = in_valid;
            slot0_d     = slot_0;
            slot1_d     = slot_1;
        end else if (out_ready) begin
            out_valid_d = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 2'b00;
            slot0_q     <= '0;
            slot1_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            slot0_q     <= slot0_d;
            slot1_q     <= slot1_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign rs1_phy_0    = slot0_q.rs1;
    assign rs2_phy_0    = slot0_q.rs2;
    assign rd_phy_0     = slot0_q.rd;
    assign rd_phy_old_0 = slot0_q.rd_old;
    assign rs1_phy_1    = slot1_q.rs1;
    assign rs2_phy_1    = slot1_q.rs2;
    assign rd_phy_1     = slot1_q.rd;
    assign rd_phy_old_1 = slot1_q.rd_old;

`ifdef RENAME_PERF_EN
    logic [31:0] stall_free_q, stall_free_d, stall_out_q, stall_out_d;

    always_comb begin
        stall_free_d = stall_free_q;
        stall_out_d  = stall_out_q;
        if (in_valid != 2'b00 && !flush && !out_busy && !free_ok && stall_free_q != '1) begin
            stall_free_d = stall_free_q + 32'd1;
        end
        if (in_valid != 2'b00 && !flush && out_busy && stall_out_q != '1) begin
            stall_out_d = stall_out_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_free_q <= '0;
            stall_out_q  <= '0;
        end else begin
            stall_free_q <= stall_free_d;
            stall_out_q  <= stall_out_d;
        end
    end

    assign stall_free_cnt = stall_free_q;
    assign stall_out_cnt  = stall_out_q;
`endif

endmodule

// File: tb/tb_rename_stage.sv
// Bench for rename_stage: directed scenarios then random traffic against a
// sequential-rename reference model of both RATs and the output bundle.
module tb_rename_stage;
    import rename_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic [1:0]            in_valid;
    logic                  in_ready;
    logic [ARCH_WIDTH-1:0] rs1_arch_0, rs2_arch_0, rd_arch_0;
    logic [ARCH_WIDTH-1:0] rs1_arch_1, rs2_arch_1, rd_arch_1;
    logic                  rd_we_0, rd_we_1;
    logic [1:0]            alloc_req;
    logic [PHY_WIDTH-1:0]  alloc_phy_0, alloc_phy_1;
    logic [FREE_CNT_W-1:0] num_free;
    logic                  retire_valid;
    logic [ARCH_WIDTH-1:0] retire_rd_arch;
    logic [PHY_WIDTH-1:0]  retire_rd_phy_new;
    logic [1:0]            out_valid;
    logic                  out_ready;
    logic [PHY_WIDTH-1:0]  rs1_phy_0, rs2_phy_0, rd_phy_0, rd_phy_old_0;
    logic [PHY_WIDTH-1:0]  rs1_phy_1, rs2_phy_1, rd_phy_1, rd_phy_old_1;

    rename_stage dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .rs1_arch_0        (rs1_arch_0),
        .rs2_arch_0        (rs2_arch_0),
        .rd_arch_0         (rd_arch_0),
        .rd_we_0           (rd_we_0),
        .rs1_arch_1        (rs1_arch_1),
        .rs2_arch_1        (rs2_arch_1),
        .rd_arch_1         (rd_arch_1),
        .rd_we_1           (rd_we_1),
        .alloc_req         (alloc_req),
        .alloc_phy_0       (alloc_phy_0),
        .alloc_phy_1       (alloc_phy_1),
        .num_free          (num_free),
        .retire_valid      (retire_valid),
        .retire_rd_arch    (retire_rd_arch),
        .retire_rd_phy_new (retire_rd_phy_new),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .rs1_phy_0         (rs1_phy_0),
        .rs2_phy_0         (rs2_phy_0),
        .rd_phy_0          (rd_phy_0),
        .rd_phy_old_0      (rd_phy_old_0),
        .rs1_phy_1         (rs1_phy_1),
        .rs2_phy_1         (rs2_phy_1),
        .rd_phy_1          (rd_phy_1),
        .rd_phy_old_1      (rd_phy_old_1)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Scoreboard state
    int checks = 0;
    int errors = 0;
    logic [49:0] exp_q[$];
    int          frat[32];
    int          crat[32];
    logic [1:0]  m_ov;
    logic [23:0] m_s0, m_s1;

    wire [49:0] dut_word = {out_valid, rs1_phy_0, rs2_phy_0, rd_phy_0, rd_phy_old_0,
                            rs1_phy_1, rs2_phy_1, rd_phy_1, rd_phy_old_1};

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            frat[i] = i;
            crat[i] = i;
        end
        m_ov = 2'b00;
        m_s0 = '0;
        m_s1 = '0;
        exp_q.delete();
    endtask

    // Driver tasks
    task automatic idle();
        flush = 0; in_valid = 2'b00;
        rs1_arch_0 = 0; rs2_arch_0 = 0; rd_arch_0 = 0; rd_we_0 = 0;
        rs1_arch_1 = 0; rs2_arch_1 = 0; rd_arch_1 = 0; rd_we_1 = 0;
        alloc_phy_0 = 0; alloc_phy_1 = 0; num_free = 6'd32; out_ready = 1;
        retire_valid = 0; retire_rd_arch = 0; retire_rd_phy_new = 0;
    endtask

    task automatic set_s0(input int rs1, input int rs2, input int rd, input logic we);
        rs1_arch_0 = 5'(rs1); rs2_arch_0 = 5'(rs2); rd_arch_0 = 5'(rd); rd_we_0 = we;
    endtask

    task automatic set_s1(input int rs1, input int rs2, input int rd, input logic we);
        rs1_arch_1 = 5'(rs1); rs2_arch_1 = 5'(rs2); rd_arch_1 = 5'(rd); rd_we_1 = we;
    endtask

    // One cycle: called at posedge+1 with inputs applied. Renaming is modelled
    // as two sequential instructions on a copy of the map.
    task automatic step();
        int tmp[32];
        logic n0, n1, rdy, fire;
        int new0, new1;
        logic [23:0] s0, s1;
        #1;
        n0   = in_valid[0] && rd_we_0 && (rd_arch_0 != 0);
        n1   = in_valid[1] && rd_we_1 && (rd_arch_1 != 0);
        rdy  = !flush && !((m_ov != 0) && !out_ready) && (int'(num_free) >= int'(n0) + int'(n1));
        fire = rdy && (in_valid != 0);
        check("in_ready", 64'(in_ready), 64'(rdy));
        check("alloc_req", 64'(alloc_req), 64'({fire && n1, fire && n0}));
        tmp  = frat;
        s0   = '0;
        s1   = '0;
        new0 = int'(alloc_phy_0);
        new1 = n0 ? int'(alloc_phy_1) : int'(alloc_phy_0);
        if (in_valid[0]) begin
            s0 = {6'(tmp[rs1_arch_0]), 6'(tmp[rs2_arch_0]),
                  n0 ? 6'(new0) : 6'd0, n0 ? 6'(tmp[rd_arch_0]) : 6'd0};
            if (n0) tmp[rd_arch_0] = new0;
        end
        if (in_valid[1]) begin
            s1 = {6'(tmp[rs1_arch_1]), 6'(tmp[rs2_arch_1]),
                  n1 ? 6'(new1) : 6'd0, n1 ? 6'(tmp[rd_arch_1]) : 6'd0};
            if (n1) tmp[rd_arch_1] = new1;
        end
        if (retire_valid && retire_rd_arch != 0) crat[retire_rd_arch] = int'(retire_rd_phy_new);
        if (flush) begin
            frat = crat; m_ov = 2'b00; m_s0 = '0; m_s1 = '0;
        end else if (fire) begin
            frat = tmp; m_ov = in_valid; m_s0 = s0; m_s1 = s1;
        end else if (out_ready) begin
            m_ov = 2'b00;
        end
        exp_q.push_back({m_ov, m_s0, m_s1});
        @(posedge clk);
        #1;
        check("bundle", 64'(dut_word), 64'(exp_q.pop_front()));
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_bundle", 64'(dut_word), 64'd0);
        in_valid = 2'b11; set_s0(1, 2, 3, 1); set_s1(4, 5, 6, 1);
        #1;
        check("rst_alloc_req", 64'(alloc_req), 64'd0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single writer: add x5, x1, x2
        in_valid = 2'b01; set_s0(1, 2, 5, 1); alloc_phy_0 = 6'd32;
        step();
        check("t1_rs1", 64'(rs1_phy_0), 64'd1);
        check("t1_rs2", 64'(rs2_phy_0), 64'd2);
        check("t1_rd", 64'(rd_phy_0), 64'd32);
        check("t1_rd_old", 64'(rd_phy_old_0), 64'd5);

        // Intra-group dependency x3 <= x1; x4 <= x3
        idle(); in_valid = 2'b11; set_s0(1, 0, 3, 1); set_s1(3, 0, 4, 1);
        alloc_phy_0 = 6'd33; alloc_phy_1 = 6'd34;
        step();
        check("t2_rs1_1", 64'(rs1_phy_1), 64'd33);
        check("t2_rd_1", 64'(rd_phy_1), 64'd34);

        // Both slots write x7
        idle(); in_valid = 2'b11; set_s0(0, 0, 7, 1); set_s1(0, 0, 7, 1);
        alloc_phy_0 = 6'd40; alloc_phy_1 = 6'd41;
        step();
        check("t3_rd_old_1", 64'(rd_phy_old_1), 64'd40);
        idle(); in_valid = 2'b01; set_s0(7, 0, 0, 0);
        step();
        check("t3_read_x7", 64'(rs1_phy_0), 64'd41);

        // Free-register shortfall stalls the whole group
        idle(); in_valid = 2'b11; set_s0(1, 2, 8, 1); set_s1(3, 4, 9, 1);
        alloc_phy_0 = 6'd42; alloc_phy_1 = 6'd43; num_free = 6'd1;
        step();
        step();
        num_free = 6'd2;
        step();
        check("t4_rd_1", 64'(rd_phy_1), 64'd43);

        // Output backpressure holds the bundle
        idle(); in_valid = 2'b01; set_s0(1, 0, 10, 1); alloc_phy_0 = 6'd44;
        step();
        set_s0(2, 0, 11, 1); alloc_phy_0 = 6'd45; out_ready = 0;
        repeat (3) step();
        check("t5_held_rd", 64'(rd_phy_0), 64'd44);
        out_ready = 1;
        step();
        check("t5_next_rd", 64'(rd_phy_0), 64'd45);

        // Retire, speculative remap, flush restores committed mapping
        idle(); retire_valid = 1; retire_rd_arch = 5'd5; retire_rd_phy_new = 6'd32;
        step();
        idle(); in_valid = 2'b01; set_s0(0, 0, 5, 1); alloc_phy_0 = 6'd50;
        step();
        idle(); flush = 1;
        step();
        check("t6_flush_valid", 64'(out_valid), 64'd0);
        idle(); in_valid = 2'b01; set_s0(5, 0, 0, 0);
        step();
        check("t6_read_x5", 64'(rs1_phy_0), 64'd32);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            int sel;
            idle();
            sel = $urandom_range(0, 2);
            in_valid = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
            set_s0($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            set_s1($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            alloc_phy_0 = 6'($urandom_range(32, 63));
            alloc_phy_1 = 6'($urandom_range(32, 63));
            num_free = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 2)) : 6'($urandom_range(2, 32));
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            retire_valid = ($urandom_range(0, 2) == 0);
            retire_rd_arch = 5'($urandom_range(0, 7));
            retire_rd_phy_new = 6'($urandom_range(0, 63));
            step();
        end

        // Asynchronous reset during an output stall
        idle(); in_valid = 2'b01; set_s0(1, 0, 12, 1); alloc_phy_0 = 6'd55;
        step();
        out_ready = 0; in_valid = 2'b11; set_s1(0, 0, 13, 1);
        step();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_bundle", 64'(dut_word), 64'd0);
        check("mid_rst_alloc", 64'(alloc_req), 64'd0);
        out_ready = 1;
        @(posedge clk);
        #1;
        check("mid_rst_alloc_edge", 64'(alloc_req), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle();
        @(posedge clk);
        #1;
        in_valid = 2'b01; set_s0(12, 13, 0, 0);
        step();
        check("post_rst_x12", 64'(rs1_phy_0), 64'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
